// File: rtl/radix64_seq_mul_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
// Shared widths, the FSM state type and two small helpers for the radix-64
// sequential multiplier controller and its partial-product generator.
//   X_W        multiplicand width (21)
//   DIGIT_W    multiplier bits retired per RUN cycle (6)
//   NUM_DIGITS digits per operation (4), so Y_W = 24
//   PP_W       partial-product / adder B width (27)
//   ADD_A_W    running high accumulator / adder A width (33)
//   SUM_W      adder sum width (34)
//   PROD_W     final product width (45)
// ----------------------------------------------------------------------------
package mul_pkg;

  localparam int X_W        = 21;
  localparam int DIGIT_W    = 6;
  localparam int NUM_DIGITS = 4;
  localparam int Y_W        = DIGIT_W * NUM_DIGITS;
  localparam int PP_W       = 27;
  localparam int ADD_A_W    = 33;
  localparam int SUM_W      = 34;
  localparam int PROD_W     = 45;
  localparam int CNT_W      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The low DIGIT_W bits of each sum are final product bits; everything
  // above them becomes the next running high accumulator.  Bit 33 of the
  // sum is always zero, so dropping it in the cast loses nothing.
  function automatic logic [ADD_A_W-1:0] next_acc_hi(input logic [SUM_W-1:0] sum);
    return ADD_A_W'(sum >> DIGIT_W);
  endfunction

  // Shift the freshly settled digit into the top of the low product word.
  function automatic logic [Y_W-1:0] next_lo(input logic [SUM_W-1:0] sum,
                                             input logic [Y_W-1:0]   lo);
    return {sum[DIGIT_W-1:0], lo[Y_W-1:DIGIT_W]};
  endfunction

endpackage

// File: rtl/radix64_seq_mul_ctrl_if.sv
// ----------------------------------------------------------------------------
// radix64_seq_mul_ctrl_if
// Operand / product handshake bundle for the radix-64 sequential multiplier.
//   in_valid/in_ready/in_x/in_y      operand pair, valid/ready
//   out_valid/out_ready/out_product  product, valid/ready
// Modports:
//   slave  - the multiplier controller (accepts operands, returns product)
//   master - the environment that issues operands and consumes products
// ----------------------------------------------------------------------------
interface radix64_seq_mul_ctrl_if;
  import mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [X_W-1:0]    in_x;
  logic [Y_W-1:0]    in_y;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_product;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_product
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_product
  );

endinterface

// File: rtl/radix64_seq_mul_ctrl_pp_gen.sv
// ----------------------------------------------------------------------------
// pp_gen_21x6
// Combinational partial-product generator: one 21-bit multiplicand times one
// 6-bit multiplier digit.  The 27-bit result cannot overflow
// ((2^21-1)*(2^6-1) < 2^27).
//   x_i   in  21  multiplicand
//   d_i   in   6  multiplier digit
//   pp_o  out 27  x_i * d_i
// ----------------------------------------------------------------------------
module pp_gen_21x6
  import mul_pkg::*;
(
  input  logic [X_W-1:0]     x_i,
  input  logic [DIGIT_W-1:0] d_i,
  output logic [PP_W-1:0]    pp_o
);

  assign pp_o = PP_W'(x_i) * PP_W'(d_i);

endmodule

// File: rtl/radix64_seq_mul_ctrl.sv
// ----------------------------------------------------------------------------
// radix64_seq_mul_ctrl
// Sequential radix-64 shift-add multiplier controller.  It sits directly
// upstream of an external 33+27->34-bit unsigned adder: each RUN cycle it
// presents the running high accumulator (add_a) and one partial product
// X * digit (add_b) to the adder and consumes the combinational sum
// (add_sum) in the same cycle.  Four digits produce the 45-bit product.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   synchronous active-low reset
//   bus       slave modport of radix64_seq_mul_ctrl_if
//               in_valid/in_ready/in_x/in_y, out_valid/out_ready/out_product
//   busy      out  1   state != IDLE
//   add_a     out 33   adder operand A (acc_hi in RUN, else 0)
//   add_b     out 27   adder operand B (partial product in RUN, else 0)
//   add_sum   in  34   adder result, same cycle
//
// Configuration:
//   EARLY_ZERO_EN  when defined, an accepted operand pair with a zero operand
//                  goes straight to DONE with product 0, skipping RUN.
// ----------------------------------------------------------------------------
module radix64_seq_mul_ctrl
  import mul_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  radix64_seq_mul_ctrl_if.slave bus,
  output logic                busy,
  output logic [ADD_A_W-1:0]  add_a,
  output logic [PP_W-1:0]     add_b,
  input  logic [SUM_W-1:0]    add_sum
);

  state_e             state_q,     state_d;
  logic [X_W-1:0]     x_q,         x_d;
  logic [Y_W-1:0]     y_q,         y_d;
  logic [ADD_A_W-1:0] acc_hi_q,    acc_hi_d;
  logic [Y_W-1:0]     lo_q,        lo_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;

  logic [PP_W-1:0]    pp;
  logic               accept;
  logic               in_run;

  // Partial product of the current low digit of the shifting multiplier.
  pp_gen_21x6 u_pp_gen (
    .x_i  (x_q),
    .d_i  (y_q[DIGIT_W-1:0]),
    .pp_o (pp)
  );

  // in_ready must drop as soon as rst_n falls, so it is not registered.
  assign bus.in_ready = rst_n && (state_q == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_run       = (state_q == RUN);

  // Adder operands are held at zero outside RUN so the downstream adder sees
  // quiet inputs and any X on add_sum outside RUN never reaches state.
  assign add_a = in_run ? acc_hi_q : '0;
  assign add_b = in_run ? pp       : '0;

  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = {acc_hi_q[X_W-1:0], lo_q};
  assign busy            = busy_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_hi_d    = acc_hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          x_d      = bus.in_x;
          y_d      = bus.in_y;
          acc_hi_d = '0;
          lo_d     = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
`ifdef EARLY_ZERO_EN
          // Zero times anything: the cleared accumulators already hold the
          // answer, so the product is ready one cycle after accept.
          if ((bus.in_x == '0) || (bus.in_y == '0)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        acc_hi_d = next_acc_hi(add_sum);
        lo_d     = next_lo(add_sum, lo_q);
        y_d      = y_q >> DIGIT_W;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Reset abandons any operation in flight; nothing is emitted afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      acc_hi_q    <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_hi_q    <= acc_hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_radix64_seq_mul_ctrl.sv
module tb_radix64_seq_mul_ctrl;
  import mul_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               busy;
  logic [ADD_A_W-1:0] add_a;
  logic [PP_W-1:0]    add_b;
  logic [SUM_W-1:0]   add_sum;

  radix64_seq_mul_ctrl_if bus ();

  radix64_seq_mul_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum)
  );

  // External adder stage.
  assign add_sum = {1'b0, add_a} + {7'b0, add_b};

  always #5 clk = ~clk;

  int vec     = 0;
  int miscmp  = 0;

  typedef struct {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [PROD_W-1:0] prod;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vec++;
    if (act !== req) begin
      miscmp++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
`ifdef EARLY_ZERO_EN
    if (x == '0 || y == '0) return 1;
`endif
    return NUM_DIGITS + 1;
  endfunction

  // Present an operand pair and hold it until accepted (bounded).
  task automatic start_op(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    check("accept_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    tick();
    bus.in_valid = 1'b0;
    // Garbage outside the accept cycle must be ignored.
    bus.in_x     = X_W'($urandom);
    bus.in_y     = Y_W'($urandom);
  endtask

  // Walk the RUN cycles, checking the adder operands against plain
  // arithmetic, until out_valid rises or the budget runs out.
  task automatic wait_done(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                           input bit chk_ops, output int lat);
    longint unsigned xm, ym, eb, ea, mask;
    xm  = 64'(x);
    ym  = 64'(y);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      if (chk_ops && lat <= NUM_DIGITS) begin
        eb   = xm * ((ym >> (DIGIT_W * (lat - 1))) & 64'd63);
        mask = (64'd1 << (DIGIT_W * (lat - 1))) - 64'd1;
        ea   = (xm * (ym & mask)) >> (DIGIT_W * (lat - 1));
        check($sformatf("add_b_digit%0d", lat - 1), 64'(add_b), eb);
        check($sformatf("add_a_digit%0d", lat - 1), 64'(add_a), ea);
      end
      tick();
      lat++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  // Full transaction with random product-side stall.
  task automatic do_op(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                       input logic [PROD_W-1:0] req, input string nm);
    int lat;
    int stall;
    start_op(x, y);
    wait_done(x, y, 1'b1, lat);
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat(x, y)));
    check({nm, "_product"}, 64'(bus.out_product), 64'(req));
    stall = $urandom_range(0, 2);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({nm, "_held"}, 64'(bus.out_product), 64'(req));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({nm, "_released"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    logic [X_W-1:0] rx;
    logic [Y_W-1:0] ry;

    tbl[0] = '{21'h1FFFFF, 24'hFFFFFF, 45'h1FFFFEE00001};
    tbl[1] = '{21'h12345,  24'h000040, 45'h48D140};
    tbl[2] = '{21'd3,      24'd5,      45'd15};
    tbl[3] = '{21'd7,      24'd9,      45'd63};
    tbl[4] = '{21'd0,      24'hABCDEF, 45'd0};
    tbl[5] = '{21'd1,      24'd1,      45'd1};
    tbl[6] = '{21'h1FFFFF, 24'd1,      45'h1FFFFF};
    tbl[7] = '{21'd1,      24'hFFFFFF, 45'hFFFFFF};

    // Reset held two cycles with in_valid asserted.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 21'd5;
    bus.in_y      = 24'd5;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  64'(bus.in_ready),    64'd0);
    check("rst_out_valid", 64'(bus.out_valid),   64'd0);
    check("rst_busy",      64'(busy),            64'd0);
    check("rst_add_a",     64'(add_a),           64'd0);
    check("rst_add_b",     64'(add_b),           64'd0);
    check("rst_product",   64'(bus.out_product), 64'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);
    check("rel_busy",     64'(busy),         64'd0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++)
      do_op(tbl[i].x, tbl[i].y, tbl[i].prod, $sformatf("tbl%0d", i));

    // Backpressure: product held for three stalled cycles.
    start_op(21'd3, 24'd5);
    wait_done(21'd3, 24'd5, 1'b0, lat);
    check("bp_latency", 64'(lat), 64'(NUM_DIGITS + 1));
    for (int i = 0; i < 3; i++) begin
      check("bp_product",   64'(bus.out_product), 64'd15);
      check("bp_out_valid", 64'(bus.out_valid),   64'd1);
      check("bp_in_ready",  64'(bus.in_ready),    64'd0);
      check("bp_busy",      64'(busy),            64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_idle_ready", 64'(bus.in_ready),  64'd1);
    check("bp_idle_valid", 64'(bus.out_valid), 64'd0);
    check("bp_idle_busy",  64'(busy),          64'd0);

    // Reset in the second RUN cycle abandons the operation.
    start_op(21'h12345, 24'h654321);
    check("mid_busy_run", 64'(busy), 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_busy",      64'(busy),          64'd0);
    check("mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_in_ready",  64'(bus.in_ready),  64'd0);
    rst_n = 1'b1;
    #1;
    check("mid_in_ready_rel", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("mid_no_product", 64'(seen), 64'd0);
    do_op(21'd7, 24'd9, 45'd63, "mid_after");

    // Zero-operand timing in both directions.
    do_op(21'd0, 24'hABCDEF, 45'd0, "zero_x");
    do_op(21'h0ABCDE, 24'd0, 45'd0, "zero_y");

    // Randomized operands against x*y.
    for (int n = 0; n < 24; n++) begin
      rx = X_W'($urandom);
      ry = Y_W'($urandom);
      if ($urandom_range(0, 7) == 0) rx = '0;
      if ($urandom_range(0, 7) == 0) ry = '0;
      do_op(rx, ry, PROD_W'(64'(rx) * 64'(ry)), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
